// File: rtl/ctrl_ramdrv_ringcnt_pkg.sv
// Shared command/direction encodings for the RAM-driver counters, plus a small
// decode helper used for waveform-readable command names.
package ctrl_ramdrv_ringcnt_pkg;

    typedef enum logic [1:0] {
        CMD_SLEEP   = 2'b00,
        CMD_COUNT   = 2'b01,
        CMD_LOAD    = 2'b10,
        CMD_ILLEGAL = 2'b11
    } cmd_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    function automatic logic [8*8-1:0] cmd_name(input cmd_e c);
        logic [8*8-1:0] s;
        s = "SLEEP   ";
        case (c)
            CMD_COUNT:   s = "COUNT   ";
            CMD_LOAD:    s = "LOAD    ";
            CMD_ILLEGAL: s = "ILLEGAL ";
            default:     s = "SLEEP   ";
        endcase
        return s;
    endfunction

endpackage

// File: rtl/ctrl_ramdrv_ringcnt_ring_ofs_step.sv
// Combinational ring offset stepper: advances an offset one position modulo (len+1)
// in the given direction and reports when the step crosses the ring boundary.
module ctrl_ramdrv_ringcnt_ring_ofs_step
    import ctrl_ramdrv_ringcnt_pkg::*;
#(
    parameter int LEN_WIDTH = 8
) (
    input  logic [LEN_WIDTH-1:0] ofs_i,
    input  logic [LEN_WIDTH-1:0] len_i,
    input  logic                 dir_i,
    output logic [LEN_WIDTH-1:0] ofs_nxt_o,
    output logic                 wrap_o
);

    always_comb begin
        ofs_nxt_o = ofs_i;
        wrap_o    = 1'b0;
        if (dir_i == DIR_UP) begin
            wrap_o    = (ofs_i == len_i);
            ofs_nxt_o = wrap_o ? '0 : ofs_i + 1'b1;
        end else begin
            wrap_o    = (ofs_i == '0);
            ofs_nxt_o = wrap_o ? len_i : ofs_i - 1'b1;
        end
    end

endmodule

// File: rtl/ctrl_ramdrv_ringcnt.sv
// Multi-channel ring-buffer address generator: per-channel base/len/offset/tap state,
// one registered address per count command, with end-of-pass, wrap and error flags.
module ctrl_ramdrv_ringcnt
    import ctrl_ramdrv_ringcnt_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int LEN_WIDTH  = 8,
    parameter int CH_NUM     = 4,
    parameter int CH_WIDTH   = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clr_i,
    input  logic                  load_i,
    input  logic                  cnt_i,
    input  logic [CH_WIDTH-1:0]   ch_sel_i,
    input  logic                  dir_in_i,
    input  logic [ADDR_WIDTH-1:0] base_in_i,
    input  logic [LEN_WIDTH-1:0]  len_in_i,
    input  logic [LEN_WIDTH-1:0]  ofs_in_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  addr_vld_o,
    output logic [CH_WIDTH-1:0]   ch_out_o,
    output logic                  last_o,
    output logic                  wrap_o,
    output logic                  err_o
);

    logic [ADDR_WIDTH-1:0] base_q [CH_NUM];
    logic [ADDR_WIDTH-1:0] base_d [CH_NUM];
    logic [LEN_WIDTH-1:0]  len_q  [CH_NUM];
    logic [LEN_WIDTH-1:0]  len_d  [CH_NUM];
    logic [LEN_WIDTH-1:0]  ofs_q  [CH_NUM];
    logic [LEN_WIDTH-1:0]  ofs_d  [CH_NUM];
    logic [LEN_WIDTH-1:0]  tap_q  [CH_NUM];
    logic [LEN_WIDTH-1:0]  tap_d  [CH_NUM];
    logic                  dir_q  [CH_NUM];
    logic                  dir_d  [CH_NUM];

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  addr_vld_q, addr_vld_d;
    logic [CH_WIDTH-1:0]   ch_out_q, ch_out_d;
    logic                  last_q, last_d;
    logic                  wrap_q, wrap_d;
    logic                  err_q, err_d;

    cmd_e                  cmd;
    logic                  ch_ok;
    logic [CH_WIDTH-1:0]   ch_idx;
    logic [ADDR_WIDTH-1:0] sel_base;
    logic [LEN_WIDTH-1:0]  sel_len;
    logic [LEN_WIDTH-1:0]  sel_ofs;
    logic [LEN_WIDTH-1:0]  sel_tap;
    logic                  sel_dir;
    logic [LEN_WIDTH-1:0]  step_ofs;
    logic                  step_wrap;
    logic                  tap_last;
    logic [ADDR_WIDTH-1:0] issue_addr;

    assign cmd    = cmd_e'({load_i, cnt_i});
    assign ch_ok  = (32'(ch_sel_i) < CH_NUM);
    // Out-of-range selects are steered to channel 0 so array reads stay in bounds;
    // the command itself is rejected via ch_ok.
    assign ch_idx = ch_ok ? ch_sel_i : '0;

    assign sel_base = base_q[ch_idx];
    assign sel_len  = len_q[ch_idx];
    assign sel_ofs  = ofs_q[ch_idx];
    assign sel_tap  = tap_q[ch_idx];
    assign sel_dir  = dir_q[ch_idx];

    assign tap_last   = (sel_tap == sel_len);
    assign issue_addr = sel_base + ADDR_WIDTH'(sel_ofs);

    ctrl_ramdrv_ringcnt_ring_ofs_step #(
        .LEN_WIDTH (LEN_WIDTH)
    ) u_ofs_step (
        .ofs_i     (sel_ofs),
        .len_i     (sel_len),
        .dir_i     (sel_dir),
        .ofs_nxt_o (step_ofs),
        .wrap_o    (step_wrap)
    );

    always_comb begin
        base_d     = base_q;
        len_d      = len_q;
        ofs_d      = ofs_q;
        tap_d      = tap_q;
        dir_d      = dir_q;
        addr_d     = addr_q;
        ch_out_d   = ch_out_q;
        addr_vld_d = 1'b0;
        last_d     = 1'b0;
        wrap_d     = 1'b0;
        err_d      = 1'b0;

        if (clr_i) begin
            for (int i = 0; i < CH_NUM; i++) begin
                base_d[i] = '0;
                len_d[i]  = '0;
                ofs_d[i]  = '0;
                tap_d[i]  = '0;
                dir_d[i]  = DIR_UP;
            end
            addr_d   = '0;
            ch_out_d = '0;
        end else begin
            case (cmd)
                CMD_LOAD: begin
                    if (!ch_ok) begin
                        err_d = 1'b1;
                    end else begin
                        base_d[ch_idx] = base_in_i;
                        len_d[ch_idx]  = len_in_i;
                        dir_d[ch_idx]  = dir_in_i;
                        tap_d[ch_idx]  = '0;
                        // A start offset outside the ring is clamped to 0 and flagged.
                        if (ofs_in_i <= len_in_i) begin
                            ofs_d[ch_idx] = ofs_in_i;
                        end else begin
                            ofs_d[ch_idx] = '0;
                            err_d         = 1'b1;
                        end
                    end
                end
                CMD_COUNT: begin
                    if (!ch_ok) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d        = issue_addr;
                        addr_vld_d    = 1'b1;
                        ch_out_d      = ch_sel_i;
                        ofs_d[ch_idx] = step_ofs;
                        wrap_d        = step_wrap;
                        tap_d[ch_idx] = tap_last ? '0 : sel_tap + 1'b1;
                        last_d        = tap_last;
                    end
                end
                CMD_ILLEGAL: err_d = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < CH_NUM; i++) begin
                base_q[i] <= '0;
                len_q[i]  <= '0;
                ofs_q[i]  <= '0;
                tap_q[i]  <= '0;
                dir_q[i]  <= DIR_UP;
            end
            addr_q     <= '0;
            addr_vld_q <= 1'b0;
            ch_out_q   <= '0;
            last_q     <= 1'b0;
            wrap_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            base_q     <= base_d;
            len_q      <= len_d;
            ofs_q      <= ofs_d;
            tap_q      <= tap_d;
            dir_q      <= dir_d;
            addr_q     <= addr_d;
            addr_vld_q <= addr_vld_d;
            ch_out_q   <= ch_out_d;
            last_q     <= last_d;
            wrap_q     <= wrap_d;
            err_q      <= err_d;
        end
    end

`ifdef CTRL_RAMDRV_RINGCNT_DEBUG
    logic [8*8-1:0] cmd_ascii_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cmd_ascii_q <= cmd_name(CMD_SLEEP);
        end else begin
            cmd_ascii_q <= cmd_name(cmd);
        end
    end
`endif

    assign addr_o     = addr_q;
    assign addr_vld_o = addr_vld_q;
    assign ch_out_o   = ch_out_q;
    assign last_o     = last_q;
    assign wrap_o     = wrap_q;
    assign err_o      = err_q;

endmodule
